// File: rtl/alu3_bcd_pkg.sv
// ---------------------------------------------------------------------------
// alu3_bcd_pkg
// Shared types and widths for the ALU3_BCD scheduler slice.
//   state_e    : scheduler FSM states (IDLE / EXEC / RESP)
//   OPW        : operand width (3 bits)
//   MODEW      : ALU mode width (2 bits)
//   DW         : BCD result width (two digits, 8 bits)
//   bin_to_bcd : 0..99 binary value -> two packed BCD digits
// ---------------------------------------------------------------------------
package alu3_bcd_pkg;

    localparam int OPW   = 3;
    localparam int MODEW = 2;
    localparam int DW    = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_e;

    // Every ALU3_BCD result is at most 63, so two BCD digits always suffice.
    function automatic logic [DW-1:0] bin_to_bcd(input logic [6:0] value);
        return {4'(value / 7'd10), 4'(value % 7'd10)};
    endfunction

endpackage

// File: rtl/ALU3_BCD.sv
// ---------------------------------------------------------------------------
// ALU3_BCD
// Combinational 3-bit arithmetic unit with a two-digit BCD result.
//   left, right : 3-bit unsigned operands
//   mode        : 0 = left + right
//                 1 = |left - right|
//                 2 = left * right
//                 3 = left * 8 + right (the 6-bit concatenation as a number)
//   data        : result as two packed BCD digits {tens, ones}
// ---------------------------------------------------------------------------
module ALU3_BCD
    import alu3_bcd_pkg::*;
(
    input  logic [OPW-1:0]   left,
    input  logic [OPW-1:0]   right,
    input  logic [MODEW-1:0] mode,
    output logic [DW-1:0]    data
);

    logic [6:0] value;

    always_comb begin
        value = '0;
        case (mode)
            2'd0:    value = 7'(left) + 7'(right);
            2'd1:    value = (left >= right) ? 7'(left - right) : 7'(right - left);
            2'd2:    value = 7'(left) * 7'(right);
            default: value = {1'b0, left, right};
        endcase
        data = bin_to_bcd(value);
    end

endmodule

// File: rtl/rr_arbiter.sv
// ---------------------------------------------------------------------------
// rr_arbiter
// Combinational round-robin arbiter. The winner is the first set bit of req
// scanning upward from last_grant+1 and wrapping at N_REQ, so the most
// recently served requester has the lowest priority but is still granted
// when it is the only one asking.
//   req        : request vector
//   last_grant : index of the previously granted requester
//   grant      : one-hot grant (zero when req is zero)
//   grant_idx  : encoded index of the grant (zero when req is zero)
// ---------------------------------------------------------------------------
module rr_arbiter #(
    parameter int N_REQ = 2,
    parameter int IDW   = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] req,
    input  logic [IDW-1:0]   last_grant,
    output logic [N_REQ-1:0] grant,
    output logic [IDW-1:0]   grant_idx
);

    logic found;

    // NOTE: every signal written here gets a default before any branch;
    // a path that leaves one unassigned would infer a latch.
    always_comb begin
        grant     = '0;
        grant_idx = '0;
        found     = 1'b0;
        // First pass: requesters strictly above the last grant.
        for (int i = 0; i < N_REQ; i++) begin
            if (!found && req[i] && (i > int'(last_grant))) begin
                grant[i]  = 1'b1;
                grant_idx = IDW'(i);
                found     = 1'b1;
            end
        end
        // Wrap-around pass: from 0 up to and including the last grant.
        for (int i = 0; i < N_REQ; i++) begin
            if (!found && req[i]) begin
                grant[i]  = 1'b1;
                grant_idx = IDW'(i);
                found     = 1'b1;
            end
        end
    end

endmodule

// File: rtl/alu3_bcd_scheduler.sv
// ---------------------------------------------------------------------------
// alu3_bcd_scheduler
// Shares one ALU3_BCD between N_REQ requesters. A round-robin winner is
// accepted in IDLE, its operands are registered and evaluated in EXEC, and
// the BCD result is held on the response channel in RESP until consumed.
//   clk, rst   : rising-edge clock, synchronous active-high reset
//   req_valid  : per-requester request valid
//   req_ready  : per-requester accept (one-hot or zero, combinational)
//   req_left   : packed 3-bit left operands, requester i at [3i+2:3i]
//   req_right  : packed 3-bit right operands, same packing
//   req_mode   : packed 2-bit ALU modes, requester i at [2i+1:2i]
//   rsp_valid  : result available (RESP state)
//   rsp_ready  : consumer accepts the result
//   rsp_data   : BCD result
//   rsp_id     : index of the requester owning rsp_data
//   busy       : high whenever the FSM is not in IDLE
// ---------------------------------------------------------------------------
module alu3_bcd_scheduler
    import alu3_bcd_pkg::*;
#(
    parameter int N_REQ = 2,
    parameter int IDW   = $clog2(N_REQ)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [N_REQ-1:0]       req_valid,
    output logic [N_REQ-1:0]       req_ready,
    input  logic [OPW*N_REQ-1:0]   req_left,
    input  logic [OPW*N_REQ-1:0]   req_right,
    input  logic [MODEW*N_REQ-1:0] req_mode,
    output logic                   rsp_valid,
    input  logic                   rsp_ready,
    output logic [DW-1:0]          rsp_data,
    output logic [IDW-1:0]         rsp_id,
    output logic                   busy
);

    state_e state_q, state_d;

    logic [OPW-1:0]   op_left, op_right;
    logic [MODEW-1:0] op_mode;
    logic [IDW-1:0]   op_id;
    logic [IDW-1:0]   last_grant;

    logic [N_REQ-1:0] grant;
    logic [IDW-1:0]   grant_idx;
    logic             accept;

    logic [OPW-1:0]   sel_left, sel_right;
    logic [MODEW-1:0] sel_mode;
    logic [DW-1:0]    alu_data;

    rr_arbiter #(
        .N_REQ (N_REQ),
        .IDW   (IDW)
    ) u_arb (
        .req        (req_valid),
        .last_grant (last_grant),
        .grant      (grant),
        .grant_idx  (grant_idx)
    );

    // One-hot mux of the winner's fields.
    always_comb begin
        sel_left  = '0;
        sel_right = '0;
        sel_mode  = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (grant[i]) begin
                sel_left  = req_left[i*OPW +: OPW];
                sel_right = req_right[i*OPW +: OPW];
                sel_mode  = req_mode[i*MODEW +: MODEW];
            end
        end
    end

    ALU3_BCD u_alu (
        .left  (op_left),
        .right (op_right),
        .mode  (op_mode),
        .data  (alu_data)
    );

    // Next state and the request handshake. Grants are suppressed while rst
    // is high so no requester believes it was served across a reset edge.
    always_comb begin
        state_d   = state_q;
        accept    = 1'b0;
        req_ready = '0;
        case (state_q)
            IDLE: begin
                if ((req_valid != '0) && !rst) begin
                    req_ready = grant;
                    accept    = 1'b1;
                    state_d   = EXEC;
                end
            end
            EXEC:    state_d = RESP;
            RESP:    if (rsp_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    assign rsp_valid = (state_q == RESP);
    assign busy      = (state_q != IDLE);

    // NOTE: state is updated with non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            op_left    <= '0;
            op_right   <= '0;
            op_mode    <= '0;
            op_id      <= '0;
            last_grant <= IDW'(N_REQ - 1);
            rsp_data   <= '0;
            rsp_id     <= '0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                op_left    <= sel_left;
                op_right   <= sel_right;
                op_mode    <= sel_mode;
                op_id      <= grant_idx;
                last_grant <= grant_idx;
            end
            if (state_q == EXEC) begin
                rsp_data <= alu_data;
                rsp_id   <= op_id;
            end
        end
    end

endmodule

// File: tb/tb_alu3_bcd_scheduler.sv
// ---------------------------------------------------------------------------
// tb_alu3_bcd_scheduler
// Self-checking bench: a transaction-level reference model tracks the
// pending operation and rotation pointer and is compared against the DUT on
// every falling edge; directed sections pin the model with literal values.
// ---------------------------------------------------------------------------
module tb_alu3_bcd_scheduler;

    localparam int N     = 2;
    localparam int IDW   = 1;
    localparam int OPW   = 3;
    localparam int MODEW = 2;

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic [N-1:0]       req_valid = '0;
    logic [N-1:0]       req_ready;
    logic [OPW*N-1:0]   req_left  = '0;
    logic [OPW*N-1:0]   req_right = '0;
    logic [MODEW*N-1:0] req_mode  = '0;
    logic               rsp_valid;
    logic               rsp_ready = 1'b0;
    logic [7:0]         rsp_data;
    logic [IDW-1:0]     rsp_id;
    logic               busy;

    int n_tests = 0;
    int n_fail  = 0;

    alu3_bcd_scheduler #(.N_REQ(N), .IDW(IDW)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_left  (req_left),
        .req_right (req_right),
        .req_mode  (req_mode),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_data  (rsp_data),
        .rsp_id    (rsp_id),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Golden ALU: plain arithmetic, then decimal digits packed as BCD.
    function automatic logic [7:0] alu_model(input int a, input int b, input int m);
        int v;
        case (m)
            0:       v = a + b;
            1:       v = (a > b) ? a - b : b - a;
            2:       v = a * b;
            default: v = a * 8 + b;
        endcase
        return 8'((v / 10) * 16 + (v % 10));
    endfunction

    function automatic int rr_pick(input logic [N-1:0] v, input int last);
        for (int k = 1; k <= N; k++) begin
            int c;
            c = (last + k) % N;
            if (v[c[IDW-1:0]]) return c;
        end
        return -1;
    endfunction

    // ---------------- reference model + per-cycle compare ----------------
    bit       m_pending  = 1'b0;
    int       m_age      = 0;
    int       m_last     = N - 1;
    logic [7:0] m_calc   = '0;
    int       m_calc_id  = 0;
    logic [7:0] m_out_data = '0;
    int       m_out_id   = 0;

    always @(negedge clk) begin
        int g;
        logic [N-1:0] e_ready;
        e_ready = '0;
        g = -1;
        if (!rst && !m_pending && (req_valid != '0)) begin
            g = rr_pick(req_valid, m_last);
            e_ready[g] = 1'b1;
        end
        check("req_ready", 32'(req_ready), 32'(e_ready));
        check("rsp_valid", 32'(rsp_valid), 32'(m_pending && (m_age >= 1)));
        check("busy",      32'(busy), 32'(m_pending));
        check("rsp_data",  32'(rsp_data), 32'(m_out_data));
        check("rsp_id",    32'(rsp_id), 32'(m_out_id));

        if (rst) begin
            m_pending  = 1'b0;
            m_last     = N - 1;
            m_out_data = '0;
            m_out_id   = 0;
        end else if (g >= 0) begin
            m_pending = 1'b1;
            m_age     = 0;
            m_calc    = alu_model(int'(req_left[OPW*g +: OPW]), int'(req_right[OPW*g +: OPW]),
                                  int'(req_mode[MODEW*g +: MODEW]));
            m_calc_id = g;
            m_last    = g;
        end else if (m_pending) begin
            if (m_age == 0) begin
                m_age      = 1;
                m_out_data = m_calc;
                m_out_id   = m_calc_id;
            end else if (rsp_ready) begin
                m_pending = 1'b0;
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic set_fields(input int i, input int a, input int b, input int m);
        req_left[OPW*i +: OPW]      = OPW'(a);
        req_right[OPW*i +: OPW]     = OPW'(b);
        req_mode[MODEW*i +: MODEW]  = MODEW'(m);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Waits (at falling edges) until req_ready[id]; leaves time at that negedge.
    task automatic wait_grant(input int id, input string name);
        bit ok;
        ok = 1'b0;
        for (int k = 0; k < 20 && !ok; k++) begin
            @(negedge clk);
            if (req_ready[id]) ok = 1'b1;
            else tick();
        end
        check(name, 32'(ok), 32'd1);
    endtask

    task automatic drain();
        bit ok;
        ok = 1'b0;
        for (int k = 0; k < 30 && !ok; k++) begin
            @(negedge clk);
            if (!busy) ok = 1'b1;
            else tick();
        end
        check("drain to idle", 32'(ok), 32'd1);
    endtask

    task automatic do_op(input int id, input int a, input int b, input int m);
        bit ok;
        req_valid     = '0;
        req_valid[id] = 1'b1;
        set_fields(id, a, b, m);
        wait_grant(id, "op grant");
        tick();
        req_valid = '0;
        ok = 1'b0;
        for (int k = 0; k < 200 && !ok; k++) begin
            @(negedge clk);
            if (rsp_valid && rsp_ready) ok = 1'b1;
            else begin
                tick();
                rsp_ready = 1'($urandom_range(0, 1));
            end
        end
        check("op response", 32'(ok), 32'd1);
        tick();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int order[6];
        int cnt;
        logic [N-1:0] granted;

        // ---- reset state ----
        rst = 1'b1;
        repeat (3) tick();
        rst = 1'b0;
        @(negedge clk);
        check("reset req_ready", 32'(req_ready), 32'd0);
        check("reset rsp_valid", 32'(rsp_valid), 32'd0);
        check("reset rsp_data",  32'(rsp_data), 32'h00);
        check("reset rsp_id",    32'(rsp_id), 32'd0);
        check("reset busy",      32'(busy), 32'd0);

        // ---- 1: single request, 7 + 5 ----
        tick();
        req_valid = 2'b01;
        set_fields(0, 7, 5, 0);
        rsp_ready = 1'b1;
        @(negedge clk);
        check("t1 req_ready same cycle", 32'(req_ready), 32'b01);
        tick();
        req_valid = '0;
        @(negedge clk);
        check("t1 exec rsp_valid", 32'(rsp_valid), 32'd0);
        check("t1 exec busy", 32'(busy), 32'd1);
        tick();
        @(negedge clk);
        check("t1 rsp_valid", 32'(rsp_valid), 32'd1);
        check("t1 rsp_data",  32'(rsp_data), 32'h12);
        check("t1 rsp_id",    32'(rsp_id), 32'd0);
        tick();

        // ---- 2: all modes and operand pairs through requester 1 ----
        for (int m = 0; m < 4; m++)
            for (int a = 0; a < 8; a++)
                for (int b = 0; b < 8; b++)
                    do_op(1, a, b, m);
        rsp_ready = 1'b1;

        // ---- 3: contention, both requesters continuously valid ----
        req_valid = 2'b11;
        set_fields(0, $urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 3));
        set_fields(1, $urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 3));
        cnt = 0;
        for (int k = 0; k < 60 && cnt < 6; k++) begin
            int g;
            @(negedge clk);
            g = -1;
            if (req_ready == 2'b01) g = 0;
            else if (req_ready == 2'b10) g = 1;
            if (g >= 0) begin
                order[cnt] = g;
                cnt++;
            end
            tick();
            if (g >= 0) set_fields(g, $urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 3));
        end
        req_valid = '0;
        check("t3 grant count", 32'(cnt), 32'd6);
        for (int i = 0; i < 6; i++) check("t3 grant order", 32'(order[i]), 32'(i % 2));
        drain();

        // ---- 4: backpressure, 6 * 7 = 42 ----
        tick();
        rsp_ready = 1'b0;
        req_valid = 2'b01;
        set_fields(0, 6, 7, 2);
        wait_grant(0, "t4 grant");
        tick();
        req_valid = 2'b11;
        begin
            bit ok;
            ok = 1'b0;
            for (int k = 0; k < 10 && !ok; k++) begin
                @(negedge clk);
                if (rsp_valid) ok = 1'b1;
                else tick();
            end
            check("t4 rsp_valid reached", 32'(ok), 32'd1);
        end
        for (int j = 0; j < 10; j++) begin
            check("t4 held rsp_data", 32'(rsp_data), 32'h42);
            check("t4 held rsp_id", 32'(rsp_id), 32'd0);
            check("t4 held req_ready", 32'(req_ready), 32'd0);
            check("t4 held busy", 32'(busy), 32'd1);
            tick();
            @(negedge clk);
        end
        tick();
        rsp_ready = 1'b1;
        req_valid = '0;
        @(negedge clk);
        check("t4 release rsp_valid", 32'(rsp_valid), 32'd1);
        tick();
        @(negedge clk);
        check("t4 idle busy", 32'(busy), 32'd0);
        check("t4 idle rsp_valid", 32'(rsp_valid), 32'd0);

        // ---- 5: reset while in EXEC ----
        tick();
        req_valid = 2'b10;
        set_fields(1, 5, 5, 0);
        wait_grant(1, "t5 grant");
        tick();
        rst = 1'b1;
        req_valid = 2'b11;
        @(negedge clk);
        check("t5 exec busy", 32'(busy), 32'd1);
        tick();
        @(negedge clk);
        check("t5 post-reset rsp_valid", 32'(rsp_valid), 32'd0);
        check("t5 post-reset rsp_data", 32'(rsp_data), 32'h00);
        check("t5 post-reset busy", 32'(busy), 32'd0);
        check("t5 no grant in reset", 32'(req_ready), 32'd0);
        tick();
        rst = 1'b0;
        @(negedge clk);
        check("t5 first grant after reset", 32'(req_ready), 32'b01);
        tick();
        req_valid = '0;
        drain();

        // ---- random traffic: withdrawals, backpressure, occasional reset ----
        tick();
        for (int c = 0; c < 1500; c++) begin
            @(negedge clk);
            granted = req_ready & req_valid;
            tick();
            for (int i = 0; i < N; i++) begin
                if (!req_valid[i] || granted[i]) begin
                    req_valid[i] = ($urandom_range(0, 2) != 0);
                    set_fields(i, $urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 3));
                end else if ($urandom_range(0, 15) == 0) begin
                    req_valid[i] = 1'b0;
                end
            end
            rsp_ready = ($urandom_range(0, 3) != 0);
            rst       = ($urandom_range(0, 299) == 0);
        end
        rst       = 1'b0;
        req_valid = '0;
        rsp_ready = 1'b1;
        drain();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
